// File: rtl/xpmwrap_arb_pkg.sv
// Shared types and the round-robin pick helper for the FIFO write arbiter.
package xpmwrap_arb_pkg;

  typedef enum logic [1:0] {ARB_RSTW, ARB_IDLE, ARB_BUSY} arb_state_t;

  localparam int STAT_W  = 32;
  localparam int MAX_REQ = 16;

  // Rotate-then-priority-encode: first set bit of req scanning ptr+1, ptr+2, ... mod n.
  // Returns the winning index, or -1 when no bit below n is set.
  function automatic int rr_next(input logic [MAX_REQ-1:0] req, input int ptr, input int n);
    int res;
    int j;
    res = -1;
    for (int k = MAX_REQ; k >= 1; k--) begin
      if (k <= n) begin
        j = ptr + k;
        if (j >= n) j = j - n;
        if (req[j]) res = j;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/xpmwrap_fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: winner is the first set req after ptr.
module xpmwrap_rr_pick
  import xpmwrap_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 hit,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IDX_W = $clog2(N);

  logic [MAX_REQ-1:0] req_ext;
  int                 pick;

  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
    pick           = rr_next(req_ext, int'(ptr), N);
    hit            = (pick != -1);
    idx            = pick[IDX_W-1:0];
  end

endmodule

// File: rtl/xpmwrap_fifo_wr_arbiter.sv
// Packet-locked round-robin arbiter driving one FIFO write port.
// Optional per-requester beat counters are built when XPMWRAP_ARB_STATS_EN is defined.
module xpmwrap_fifo_wr_arbiter
  import xpmwrap_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  localparam int IDX_W     = $clog2(NUM_REQ)
) (
  input  logic                          wr_clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic                          fifo_wr_en,
  input  logic                          fifo_full,
  input  logic                          fifo_wr_rst_busy,
  output logic                          grant_valid,
  output logic [IDX_W-1:0]              grant_id,
  output logic [NUM_REQ*STAT_W-1:0]     stat_beats
);

  // Handshake: a beat moves when req_valid[i] & req_ready[i] in the same cycle;
  // only the holder ever sees ready, and that beat goes straight to fifo_wr_en.

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [IDX_W-1:0] gid_nxt;
  logic             gv_nxt;
  logic             pick_hit;
  logic [IDX_W-1:0] pick_idx;

  xpmwrap_rr_pick #(.N(NUM_REQ)) u_pick (
    .req (req_valid),
    .ptr (ptr),
    .hit (pick_hit),
    .idx (pick_idx)
  );

  always_comb begin
    req_ready  = '0;
    fifo_wr_en = 1'b0;
    fifo_din   = '0;
    if (state == ARB_BUSY) begin
      req_ready[grant_id] = ~fifo_full & ~fifo_wr_rst_busy;
      fifo_wr_en          = req_valid[grant_id] & ~fifo_full & ~fifo_wr_rst_busy;
      fifo_din            = req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gv_nxt    = grant_valid;
    gid_nxt   = grant_id;
    case (state)
      ARB_RSTW: begin
        if (!fifo_wr_rst_busy) state_nxt = ARB_IDLE;
      end
      ARB_IDLE: begin
        if (fifo_wr_rst_busy) begin
          state_nxt = ARB_RSTW;
        end else if (pick_hit) begin
          state_nxt = ARB_BUSY;
          gv_nxt    = 1'b1;
          gid_nxt   = pick_idx;
        end
      end
      ARB_BUSY: begin
        // A FIFO reset aborts the packet; ptr is left alone so fairness is unaffected.
        if (fifo_wr_rst_busy) begin
          state_nxt = ARB_RSTW;
          gv_nxt    = 1'b0;
          gid_nxt   = '0;
        end else if (fifo_wr_en && req_last[grant_id]) begin
          state_nxt = ARB_IDLE;
          ptr_nxt   = grant_id;
          gv_nxt    = 1'b0;
          gid_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ARB_RSTW;
        gv_nxt    = 1'b0;
        gid_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      state       <= ARB_RSTW;
      ptr         <= IDX_W'(NUM_REQ - 1);
      grant_valid <= 1'b0;
      grant_id    <= '0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      grant_valid <= gv_nxt;
      grant_id    <= gid_nxt;
    end
  end

`ifdef XPMWRAP_ARB_STATS_EN
  logic [STAT_W-1:0] beat_cnt [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stats
    always_ff @(posedge wr_clk) begin
      if (rst) begin
        beat_cnt[i] <= '0;
      end else if (req_valid[i] && req_ready[i] && (beat_cnt[i] != '1)) begin
        beat_cnt[i] <= beat_cnt[i] + 1'b1;
      end
    end
    assign stat_beats[i*STAT_W +: STAT_W] = beat_cnt[i];
  end
`else
  assign stat_beats = '0;
`endif

endmodule

// File: tb/tb_xpmwrap_fifo_wr_arbiter.sv
// Bench for xpmwrap_fifo_wr_arbiter: directed scenarios plus random traffic against a packet-level model.
module tb_xpmwrap_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  // ---------------- clock / reset / DUT ----------------
  logic            wr_clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_last, req_ready;
  logic [N*DW-1:0] req_data;
  logic [DW-1:0]   fifo_din;
  logic            fifo_wr_en, fifo_full, fifo_wr_rst_busy, grant_valid;
  logic [IW-1:0]   grant_id;
  logic [N*32-1:0] stat_beats;

  always #5 wr_clk = ~wr_clk;

  xpmwrap_fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .wr_clk(wr_clk), .rst(rst), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .fifo_din(fifo_din),
    .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full), .fifo_wr_rst_busy(fifo_wr_rst_busy),
    .grant_valid(grant_valid), .grant_id(grant_id), .stat_beats(stat_beats)
  );

  // ---------------- checking ----------------
  int n_vectors = 0;
  int n_miscompares = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int            m_holder;   // requester owning the FIFO, -1 when none
  int            m_last;     // last requester to finish a packet
  bit            m_rstw;     // waiting for the FIFO to leave reset
  logic [31:0]   m_cnt [N];
  logic [DW-1:0] exp_q [$];

  task automatic model_reset();
    m_rstw = 1; m_holder = -1; m_last = N - 1;
    for (int i = 0; i < N; i++) m_cnt[i] = '0;
  endtask

  // ---------------- stimulus state ----------------
  bit   en [N];
  int   beat [N], len [N], seq [N], lmin [N], lmax [N];
  int   vprob = 100;
  bit   simple_data = 0;
  int   wr_count = 0;
  int   cyc = 0;
  logic [DW-1:0] wr_log [$];
  int   wr_cycle [$];

  task automatic set_lens(input int lo, input int hi);
    for (int i = 0; i < N; i++) begin lmin[i] = lo; lmax[i] = hi; len[i] = lo; beat[i] = 0; end
  endtask

  task automatic set_en(input logic [N-1:0] mask);
    for (int i = 0; i < N; i++) en[i] = mask[i];
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = en[i] && ($urandom_range(0, 99) < vprob);
      req_last[i]  = (beat[i] == len[i] - 1);
      req_data[i*DW +: DW] = simple_data ? DW'(i) : {8'(i), 24'(seq[i])};
    end
  endtask

  // Compare the current cycle against the model, then advance one clock.
  task automatic tick();
    logic [N-1:0]  e_rdy, acc;
    logic          e_wen;
    logic [DW-1:0] e_din;
    int            j;
    bit            found;
    #1;
    e_rdy = '0; e_wen = 0; e_din = '0;
    if (m_holder >= 0) begin
      e_din = req_data[m_holder*DW +: DW];
      if (!fifo_full && !fifo_wr_rst_busy) e_rdy[m_holder] = 1'b1;
      e_wen = e_rdy[m_holder] & req_valid[m_holder];
    end
    check_eq("grant_valid", 32'(grant_valid), 32'(m_holder >= 0));
    check_eq("grant_id", 32'(grant_id), (m_holder >= 0) ? m_holder : 0);
    check_eq("req_ready", 32'(req_ready), 32'(e_rdy));
    check_eq("fifo_wr_en", 32'(fifo_wr_en), 32'(e_wen));
    check_eq("fifo_din", fifo_din, e_din);
    if (e_wen) exp_q.push_back(e_din);
    if (fifo_wr_en) begin
      wr_count++;
      wr_log.push_back(fifo_din);
      wr_cycle.push_back(cyc);
      if (exp_q.size() != 0) check_eq("sb_data", fifo_din, exp_q.pop_front());
      else check_eq("sb_underflow", 32'(fifo_wr_en), 0);
    end
    acc = req_valid & req_ready;
    if (e_wen && m_cnt[m_holder] != 32'hFFFF_FFFF) m_cnt[m_holder] = m_cnt[m_holder] + 1;
    if (rst) begin
      model_reset();
    end else if (m_rstw) begin
      if (!fifo_wr_rst_busy) m_rstw = 0;
    end else if (fifo_wr_rst_busy) begin
      m_rstw = 1; m_holder = -1;
    end else if (m_holder < 0) begin
      found = 0;
      for (int k = 1; k <= N; k++) begin
        j = (m_last + k) % N;
        if (!found && req_valid[j]) begin found = 1; m_holder = j; end
      end
    end else if (e_wen && req_last[m_holder]) begin
      m_last = m_holder; m_holder = -1;
    end
    @(posedge wr_clk); #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        seq[i]++;
        if (beat[i] == len[i] - 1) begin
          beat[i] = 0;
          len[i]  = $urandom_range(lmin[i], lmax[i]);
        end else beat[i]++;
      end
    end
  endtask

  task automatic step();
    drive();
    tick();
  endtask

  task automatic do_reset();
    rst = 1; fifo_full = 0; fifo_wr_rst_busy = 0;
    step();
    rst = 0;
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int w0, base, p, s0;
    logic [DW-1:0] v;
    for (int i = 0; i < N; i++) seq[i] = 0;
    set_en('0); set_lens(1, 1);
    rst = 1; fifo_full = 0; fifo_wr_rst_busy = 1;
    drive();
    repeat (2) @(posedge wr_clk);
    #1;
    model_reset();

    // 1: FIFO still in reset, all requesters valid.
    rst = 0; set_en('1); vprob = 100;
    w0 = wr_count;
    repeat (5) step();
    check_eq("t1_no_writes", wr_count - w0, 0);
    fifo_wr_rst_busy = 0;
    repeat (2) step();
    check_eq("t1_first_grant_v", 32'(grant_valid), 1);
    check_eq("t1_first_grant_id", 32'(grant_id), 0);

    // 2: all single-beat, data = id.
    do_reset();
    simple_data = 1; set_en('1); set_lens(1, 1);
    w0 = wr_count; base = wr_log.size();
    for (int c = 0; c < 400 && (wr_count - w0) < 40; c++) step();
    set_en('0);
    check_eq("t2_writes", wr_count - w0, 40);
    for (int k = 0; k < 40 && base + k < wr_log.size(); k++) begin
      check_eq("t2_order", wr_log[base+k], k % 4);
      if (k > 0) check_eq("t2_spacing", wr_cycle[base+k] - wr_cycle[base+k-1], 2);
    end
    for (int i = 0; i < N; i++) begin
`ifdef XPMWRAP_ARB_STATS_EN
      check_eq("t2_stat", stat_beats[i*32 +: 32], 10);
`else
      check_eq("t2_stat", stat_beats[i*32 +: 32], 0);
`endif
    end

    // 3: req2 4-beat packet, req0 always valid with 1-beat packets.
    do_reset();
    simple_data = 0; set_lens(1, 1);
    lmin[2] = 4; lmax[2] = 4; len[2] = 4;
    set_en(4'b0101);
    base = wr_log.size();
    repeat (30) step();
    p = -1;
    for (int k = base; k < wr_log.size(); k++) begin
      v = wr_log[k];
      if (p < 0 && v[31:24] == 8'd2) p = k;
    end
    check_eq("t3_req2_seen", 32'(p >= 0), 1);
    if (p >= 0 && p + 4 < wr_log.size()) begin
      for (int k = 0; k < 5; k++) begin
        v = wr_log[p+k];
        check_eq("t3_contig_id", 32'(v[31:24]), (k < 4) ? 2 : 0);
      end
    end

    // 4: FIFO full for 3 cycles while beat 2 of 4 is pending.
    do_reset();
    set_en('0); set_lens(4, 4); set_en(4'b0010);
    s0 = seq[1]; w0 = wr_count; base = wr_log.size();
    for (int c = 0; c < 20 && (wr_count - w0) < 1; c++) step();
    fifo_full = 1;
    for (int c = 0; c < 3; c++) begin
      drive(); #1;
      check_eq("t4_ready_stall", 32'(req_ready), 0);
      check_eq("t4_wr_en_stall", 32'(fifo_wr_en), 0);
      tick();
    end
    fifo_full = 0;
    repeat (3) step();
    set_en('0);
    check_eq("t4_writes", wr_count - w0, 4);
    for (int k = 0; k < 4 && base + k < wr_log.size(); k++) begin
      v = wr_log[base+k];
      check_eq("t4_order", 32'(v[23:0]), 32'(24'(s0 + k)));
    end

    // 5: rst during beat 3 of a 5-beat packet.
    do_reset();
    set_lens(5, 5); set_en(4'b0010);
    w0 = wr_count;
    for (int c = 0; c < 20 && (wr_count - w0) < 2; c++) step();
    rst = 1;
    step();
    rst = 0;
    drive(); #1;
    check_eq("t5_grant_valid", 32'(grant_valid), 0);
    check_eq("t5_grant_id", 32'(grant_id), 0);
    check_eq("t5_ready", 32'(req_ready), 0);
    check_eq("t5_wr_en", 32'(fifo_wr_en), 0);
    check_eq("t5_stat1", stat_beats[63:32], 0);
    fifo_wr_rst_busy = 1; set_en('1);
    repeat (3) step();
    fifo_wr_rst_busy = 0;
    repeat (2) step();
    check_eq("t5_grant_v", 32'(grant_valid), 1);
    check_eq("t5_first_winner", 32'(grant_id), 0);

    // Random traffic with full back-pressure, FIFO reset pulses and occasional rst.
    set_en('1); set_lens(1, 6); vprob = 60;
    for (int c = 0; c < 3000; c++) begin
      fifo_full        = ($urandom_range(0, 99) < 25);
      fifo_wr_rst_busy = ($urandom_range(0, 99) < 3);
      rst              = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 0; fifo_full = 0; fifo_wr_rst_busy = 0; set_en('0);
    repeat (3) step();
    check_eq("sb_drain", exp_q.size(), 0);
    for (int i = 0; i < N; i++) begin
`ifdef XPMWRAP_ARB_STATS_EN
      check_eq("stat_final", stat_beats[i*32 +: 32], m_cnt[i]);
`else
      check_eq("stat_final", stat_beats[i*32 +: 32], 0);
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
